// File: rtl/cmd_rx_pkg.sv
// Shared definitions for the UART command receiver and its control-side consumers.
package cmd_rx_pkg;

    // Bit-level receive FSM encoding
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } bit_state_t;

    // Index of the final byte of a three-byte command frame
    localparam int unsigned BYTE_IDX_LAST = 2;

    // Command field positions within cfg_data
    localparam int unsigned OP_MSB   = 19;
    localparam int unsigned OP_LSB   = 18;
    localparam int unsigned ADDR_MSB = 17;
    localparam int unsigned ADDR_LSB = 16;
    localparam int unsigned DATA_MSB = 13;
    localparam int unsigned DATA_LSB = 0;

    // Field extractors for the control FSM
    function automatic logic [1:0] cmd_op(input logic [23:0] frame);
        return frame[OP_MSB:OP_LSB];
    endfunction

    function automatic logic [1:0] cmd_addr(input logic [23:0] frame);
        return frame[ADDR_MSB:ADDR_LSB];
    endfunction

    function automatic logic [13:0] cmd_data(input logic [23:0] frame);
        return frame[DATA_MSB:DATA_LSB];
    endfunction

endpackage

// File: rtl/cmd_rx.sv
// UART 8N1 receiver that assembles three bytes into a 24-bit command frame,
// with overrun, framing-error and inter-byte timeout handling.
module cmd_rx
    import cmd_rx_pkg::*;
#(
    parameter int unsigned BAUD_DIV = 1302,
    parameter int unsigned TO_BITS  = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx,
    input  logic        clr_rdy,
    output logic [23:0] cfg_data,
    output logic        frm_rdy,
    output logic        ovr,
    output logic        frm_err
);

    localparam int unsigned BAUD_W   = $clog2(BAUD_DIV + 1);
    localparam int unsigned TO_LIMIT = TO_BITS * BAUD_DIV;
    localparam int unsigned TO_W     = $clog2(TO_LIMIT + 1);

    logic              rx_meta;
    logic              rx_s;
    bit_state_t        state;
    logic [BAUD_W-1:0] baud_cnt;
    logic [2:0]        bit_cnt;
    logic [7:0]        shift_reg;
    logic [1:0]        byte_idx;
    logic [15:0]       shadow;
    logic [TO_W-1:0]   to_cnt;
    logic              baud_exp_c;

    // Bit period expires on the last cycle of a loaded count
    assign baud_exp_c = (baud_cnt == BAUD_W'(1));

    // Two-flop synchronizer, idle-high reset value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // Bit FSM, byte assembly, frame handoff, timeout and error reporting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            byte_idx  <= '0;
            shadow    <= '0;
            to_cnt    <= '0;
            cfg_data  <= '0;
            frm_rdy   <= 1'b0;
            ovr       <= 1'b0;
            frm_err   <= 1'b0;
        end else begin
            frm_err <= 1'b0;
            // Acknowledge; a coincident frame completion below overrides it
            if (clr_rdy) begin
                frm_rdy <= 1'b0;
                ovr     <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (!rx_s) begin
                        baud_cnt <= BAUD_W'(BAUD_DIV / 2);
                        to_cnt   <= '0;
                        state    <= ST_START;
                    end else if (byte_idx != 2'd0) begin
                        if (to_cnt == TO_W'(TO_LIMIT - 1)) begin
                            to_cnt   <= '0;
                            byte_idx <= 2'd0;
                            frm_err  <= 1'b1;
                        end else begin
                            to_cnt <= to_cnt + TO_W'(1);
                        end
                    end else begin
                        to_cnt <= '0;
                    end
                end
                ST_START: begin
                    if (baud_exp_c) begin
                        if (!rx_s) begin
                            baud_cnt <= BAUD_W'(BAUD_DIV);
                            bit_cnt  <= 3'd0;
                            state    <= ST_DATA;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - BAUD_W'(1);
                    end
                end
                ST_DATA: begin
                    if (baud_exp_c) begin
                        shift_reg <= {rx_s, shift_reg[7:1]};
                        baud_cnt  <= BAUD_W'(BAUD_DIV);
                        if (bit_cnt == 3'd7) begin
                            state <= ST_STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - BAUD_W'(1);
                    end
                end
                ST_STOP: begin
                    if (baud_exp_c) begin
                        state <= ST_IDLE;
                        if (rx_s) begin
                            if (byte_idx == 2'(BYTE_IDX_LAST)) begin
                                cfg_data <= {shadow, shift_reg};
                                frm_rdy  <= 1'b1;
                                byte_idx <= 2'd0;
                                if (frm_rdy && !clr_rdy) begin
                                    ovr <= 1'b1;
                                end
                            end else begin
                                if (byte_idx == 2'd0) begin
                                    shadow[15:8] <= shift_reg;
                                end else begin
                                    shadow[7:0] <= shift_reg;
                                end
                                byte_idx <= byte_idx + 2'd1;
                            end
                        end else begin
                            frm_err  <= 1'b1;
                            byte_idx <= 2'd0;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - BAUD_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cmd_rx.sv
// Self-checking bench for cmd_rx: directed frames plus randomized byte streams
// against a frame-level reference model.
module tb_cmd_rx;
    import cmd_rx_pkg::*;

    localparam int unsigned BD  = 16;
    localparam int unsigned TOB = 20;
    // Posedge (counted from the start-bit drive) where the stop bit is judged:
    // two synchronizer flops, one detect edge, half a bit, then nine whole bits.
    localparam int STOP_EDGE = 3 + BD / 2 + 9 * BD;
    localparam int SHORT_MIN = 2 * BD;
    localparam int SHORT_MAX = 3 * BD;
    localparam int LONG_GAP  = TOB * BD + 4 * BD;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx;
    logic        clr_rdy;
    logic [23:0] cfg_data;
    logic        frm_rdy;
    logic        ovr;
    logic        frm_err;

    always #5 clk = ~clk;

    cmd_rx #(.BAUD_DIV(BD), .TO_BITS(TOB)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx       (rx),
        .clr_rdy  (clr_rdy),
        .cfg_data (cfg_data),
        .frm_rdy  (frm_rdy),
        .ovr      (ovr),
        .frm_err  (frm_err)
    );

    int n_vec  = 0;
    int n_miss = 0;
    int n_err_pulse = 0;
    int n_wide = 0;
    logic err_prev = 1'b0;

    // Frame-level reference model state
    logic [7:0]  m_q[$];
    logic [23:0] m_cfg;
    logic        m_rdy;
    logic        m_ovr;
    int          m_err;

    // Count frm_err pulses and flag any pulse longer than one cycle
    always @(negedge clk) begin
        if (frm_err) begin
            n_err_pulse = n_err_pulse + 1;
            if (err_prev) n_wide = n_wide + 1;
        end
        err_prev = frm_err;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Serialize one 8N1 byte; optionally pulse clr_rdy into a given posedge
    task automatic send_byte(input logic [7:0] d, input logic stop, input int gap,
                             input int clr_edge, output int rise);
        logic [9:0] fr;
        logic       was;
        fr   = {stop, d, 1'b0};
        was  = frm_rdy;
        rise = -1;
        for (int c = 0; c < int'(10 * BD); c++) begin
            rx      = fr[4'(c / int'(BD))];
            clr_rdy = (c + 1 == clr_edge);
            @(negedge clk);
            if (!was && frm_rdy && rise < 0) rise = c + 1;
        end
        rx      = 1'b1;
        clr_rdy = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    // Send a byte, advance the model, and compare all outputs
    task automatic xfer(input logic [7:0] d, input logic stop, input int gap,
                        input int clr_edge, input string tag, output int rise);
        send_byte(d, stop, gap, clr_edge, rise);
        if (!stop) begin
            m_err++;
            m_q.delete();
        end else begin
            m_q.push_back(d);
            if (m_q.size() == 3) begin
                m_cfg = {m_q[0], m_q[1], m_q[2]};
                m_ovr = (clr_edge > 0) ? 1'b0 : (m_ovr | m_rdy);
                m_rdy = 1'b1;
                m_q.delete();
            end else if (gap > int'(TOB * BD)) begin
                m_err++;
                m_q.delete();
            end
        end
        chk($sformatf("%s cfg_data", tag), 32'(cfg_data), 32'(m_cfg));
        chk($sformatf("%s frm_rdy", tag), 32'(frm_rdy), 32'(m_rdy));
        chk($sformatf("%s ovr", tag), 32'(ovr), 32'(m_ovr));
        chk($sformatf("%s frm_err_count", tag), 32'(n_err_pulse), 32'(m_err));
    endtask

    task automatic pulse_clr(input string tag);
        clr_rdy = 1'b1;
        @(negedge clk);
        clr_rdy = 1'b0;
        m_rdy = 1'b0;
        m_ovr = 1'b0;
        chk($sformatf("%s frm_rdy", tag), 32'(frm_rdy), 32'(m_rdy));
        chk($sformatf("%s ovr", tag), 32'(ovr), 32'(m_ovr));
        chk($sformatf("%s cfg_data", tag), 32'(cfg_data), 32'(m_cfg));
    endtask

    task automatic model_reset();
        m_q.delete();
        m_cfg = '0;
        m_rdy = 1'b0;
        m_ovr = 1'b0;
    endtask

    // Bound total runtime
    initial begin
        repeat (100000) @(posedge clk);
        $display("FAIL watchdog: got no finish expected finish within budget");
        $fatal(1);
    end

    initial begin
        int r;
        logic [7:0] d;
        logic       stop;
        int         gap;

        rst_n = 1'b0; rx = 1'b1; clr_rdy = 1'b0;
        m_err = 0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset cfg_data", 32'(cfg_data), 32'h0);
        chk("reset frm_rdy", 32'(frm_rdy), 32'h0);
        chk("reset ovr", 32'(ovr), 32'h0);
        chk("reset frm_err", 32'(frm_err), 32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Basic frame and output latency
        xfer(8'h0C, 1'b1, SHORT_MIN, 0, "f1b0", r);
        xfer(8'h12, 1'b1, SHORT_MIN, 0, "f1b1", r);
        chk("f1 not early", 32'(frm_rdy), 32'h0);
        xfer(8'h34, 1'b1, SHORT_MIN, 0, "f1b2", r);
        chk("f1 rise within stop bit", 32'(r >= int'(9 * BD + 1) && r <= int'(10 * BD)), 32'h1);
        chk("f1 cfg const", 32'(cfg_data), 32'h0C1234);
        chk("f1 op", 32'(cmd_op(cfg_data)), 32'h3);

        // Acknowledge keeps cfg_data
        pulse_clr("clr1");

        // Short low glitch is a false start
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (SHORT_MIN) @(negedge clk);
        chk("glitch frm_err_count", 32'(n_err_pulse), 32'(m_err));
        chk("glitch frm_rdy", 32'(frm_rdy), 32'h0);
        xfer(8'h01, 1'b1, SHORT_MIN, 0, "f2b0", r);
        xfer(8'h02, 1'b1, SHORT_MIN, 0, "f2b1", r);
        xfer(8'h03, 1'b1, SHORT_MIN, 0, "f2b2", r);
        chk("f2 cfg const", 32'(cfg_data), 32'h010203);
        pulse_clr("clr2");

        // Framing error discards the partial frame
        xfer(8'h55, 1'b1, SHORT_MIN, 0, "fe b0", r);
        xfer(8'h66, 1'b0, SHORT_MIN, 0, "fe bad", r);
        xfer(8'hA5, 1'b1, SHORT_MIN, 0, "f3b0", r);
        xfer(8'h00, 1'b1, SHORT_MIN, 0, "f3b1", r);
        xfer(8'h01, 1'b1, SHORT_MIN, 0, "f3b2", r);
        chk("f3 cfg const", 32'(cfg_data), 32'hA50001);
        pulse_clr("clr3");

        // Inter-byte timeout
        xfer(8'h04, 1'b1, SHORT_MIN, 0, "to b0", r);
        xfer(8'h05, 1'b1, LONG_GAP, 0, "to b1", r);
        xfer(8'h07, 1'b1, SHORT_MIN, 0, "f4b0", r);
        xfer(8'h08, 1'b1, SHORT_MIN, 0, "f4b1", r);
        xfer(8'h09, 1'b1, SHORT_MIN, 0, "f4b2", r);
        chk("f4 cfg const", 32'(cfg_data), 32'h070809);

        // Overrun while frm_rdy still set, then completion coinciding with clr_rdy
        xfer(8'h11, 1'b1, SHORT_MIN, 0, "ov b0", r);
        xfer(8'h22, 1'b1, SHORT_MIN, 0, "ov b1", r);
        xfer(8'h33, 1'b1, SHORT_MIN, 0, "ov b2", r);
        chk("ov cfg const", 32'(cfg_data), 32'h112233);
        chk("ov flag", 32'(ovr), 32'h1);
        xfer(8'h44, 1'b1, SHORT_MIN, 0, "co b0", r);
        xfer(8'h55, 1'b1, SHORT_MIN, 0, "co b1", r);
        xfer(8'h66, 1'b1, SHORT_MIN, STOP_EDGE, "co b2", r);
        chk("co frm_rdy", 32'(frm_rdy), 32'h1);
        chk("co ovr", 32'(ovr), 32'h0);
        pulse_clr("clr4");

        // Reset in the middle of a frame discards partial data
        xfer(8'hDE, 1'b1, SHORT_MIN, 0, "rs b0", r);
        xfer(8'hAD, 1'b1, SHORT_MIN, 0, "rs b1", r);
        rx = 1'b0;
        repeat (50) @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        rst_n = 1'b1;
        model_reset();
        repeat (SHORT_MIN) @(negedge clk);
        chk("midrst cfg_data", 32'(cfg_data), 32'h0);
        chk("midrst frm_rdy", 32'(frm_rdy), 32'h0);
        xfer(8'hBE, 1'b1, SHORT_MIN, 0, "f5b0", r);
        xfer(8'hEF, 1'b1, SHORT_MIN, 0, "f5b1", r);
        xfer(8'h42, 1'b1, SHORT_MIN, 0, "f5b2", r);
        chk("f5 cfg const", 32'(cfg_data), 32'hBEEF42);

        // Randomized byte stream with errors, timeouts and acknowledges
        for (int i = 0; i < 40; i++) begin
            d    = 8'($urandom_range(0, 255));
            stop = ($urandom_range(0, 7) != 0);
            gap  = ($urandom_range(0, 5) == 0) ? LONG_GAP : int'($urandom_range(SHORT_MIN, SHORT_MAX));
            xfer(d, stop, gap, 0, $sformatf("rnd%0d", i), r);
            if ($urandom_range(0, 3) == 0) pulse_clr($sformatf("rndclr%0d", i));
        end

        chk("frm_err single cycle", 32'(n_wide), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/cmd_rx.md
CMD_RX -- requirements
Module: cmd_rx

Interface
REQ-001 SHALL have parameter BAUD_DIV, default 1302, meaning clk cycles per UART bit time (minimum 8).
REQ-002 SHALL have parameter TO_BITS, default 20, meaning inter-byte timeout in bit times.
REQ-003 SHALL have port clk, input, 1 bit: system clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port rx, input, 1 bit: asynchronous UART serial line, idle high, 8N1, LSB first.
REQ-006 SHALL have port clr_rdy, input, 1 bit: single-cycle acknowledge from control FSM.
REQ-007 SHALL have port cfg_data, output, 24 bits: last complete command frame; byte 0 lands in [23:16], byte 1 in [15:8], byte 2 in [7:0].
REQ-008 SHALL have port frm_rdy, output, 1 bit: a complete frame is held in cfg_data and is unacknowledged.
REQ-009 SHALL have port ovr, output, 1 bit: sticky flag, a frame completed while frm_rdy was already 1.
REQ-010 SHALL have port frm_err, output, 1 bit: one-cycle pulse on a framing error or an inter-byte timeout.

Function
REQ-011 SHALL pass rx through a 2-flop synchronizer; both flops reset to 1.
REQ-012 SHALL implement bit FSM IDLE, START, DATA, STOP.
REQ-013 IDLE: a synced rx of 0 SHALL load baud_cnt with BAUD_DIV/2 and enter START.
REQ-014 START: at baud_cnt expiry, rx=0 SHALL load baud_cnt with BAUD_DIV, clear bit_cnt and enter DATA; rx=1 (false start) SHALL return to IDLE with no other effect.
REQ-015 DATA: each expiry SHALL shift rx into the MSB of an 8-bit shift register and reload baud_cnt; after the 8th sample the FSM SHALL enter STOP.
REQ-016 STOP: at expiry, rx=1 SHALL accept the byte; rx=0 SHALL pulse frm_err, clear byte_idx to 0, and discard the partial frame. Both cases SHALL return to IDLE.
REQ-017 Accepted bytes with byte_idx 0 or 1 SHALL be stored in a 16-bit shadow register, and byte_idx SHALL increment.
REQ-018 The byte with byte_idx 2 SHALL load cfg_data = {shadow, byte} and set frm_rdy in the same cycle, and byte_idx SHALL wrap to 0.
REQ-019 Latency: cfg_data and frm_rdy SHALL be valid 1 clk after the stop-bit sample of byte 2.
REQ-020 cfg_data SHALL change only on frame completion; it stays stable through and after clr_rdy.
REQ-021 clr_rdy SHALL clear frm_rdy and ovr on the next clk edge.
REQ-022 If frame completion coincides with clr_rdy, completion SHALL win: frm_rdy=1, cfg_data updated, and ovr is not set.
REQ-023 If a frame completes while frm_rdy=1 and clr_rdy=0, the block SHALL overwrite cfg_data and set ovr.
REQ-024 Timeout: while byte_idx≠0 and FSM is in IDLE, a counter SHALL run; reaching TO_BITS×BAUD_DIV clks SHALL reset byte_idx to 0 and pulse frm_err. Any start detection SHALL clear the counter.
REQ-025 frm_err SHALL never be asserted for more than one cycle per event.

Reset
REQ-026 rst_n low SHALL force cfg_data=0, frm_rdy=0, ovr=0, frm_err=0, FSM=IDLE, byte_idx=0, and all counters to 0.
REQ-027 Reset asserted mid-byte or mid-frame SHALL discard all partial data; the first frame after release SHALL require three fresh bytes.

Structure
REQ-028 The shared package SHALL hold the bit-FSM state encoding, the byte_idx last-value constant (2), and the cmd field positions used by control: op [19:18], addr [17:16], data [13:0].
REQ-029 SHALL be one module with no sub-modules; the synchronizer SHALL be inline.

Verification (bench uses BAUD_DIV=16, TO_BITS=20)
REQ-030 Send bytes 0x0C, 0x12, 0x34 -> cfg_data=0x0C1234 (op=2'b11), frm_rdy=1, one clk after the third stop-bit sample; ovr=0.
REQ-031 With frm_rdy=1, pulse clr_rdy for 1 clk -> frm_rdy=0 next edge, cfg_data stays 0x0C1234.
REQ-032 Drive rx low for 4 clks in IDLE -> no byte accepted, byte_idx=0, no frm_err; then send 0x01, 0x02, 0x03 -> cfg_data=0x010203.
REQ-033 Send byte 0x55 then byte 0x66 with stop bit 0 -> frm_err pulses 1 clk; then send 0xA5, 0x00, 0x01 -> cfg_data=0xA50001.
REQ-034 Send 0x04, 0x05, then idle 320+ clks -> frm_err pulses 1 clk; then send 0x07, 0x08, 0x09 -> cfg_data=0x070809.
REQ-035 With frm_rdy=1 held, complete frame 0x112233 -> ovr=1, cfg_data=0x112233; then repeat with clr_rdy pulsed in the completion cycle -> frm_rdy=1, ovr=0.
